// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike accumulation with shift leak,
// saturating sum, programmable threshold and a fixed refractory window.
module lif_neuron #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned W          = 8,
    parameter int unsigned LEAK_SHIFT = 1,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned AW        = $clog2(N_IN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N_IN-1:0] in_spk,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    output logic          spike,
    output logic [W-1:0]  state,
    output logic          refrac
);

    localparam int unsigned SW = W + AW;
    localparam int unsigned CW = 4;

    logic [W-1:0]  weight_q [N_IN];
    logic [W-1:0]  weight_d [N_IN];
    logic [W-1:0]  thr_q, thr_d;
    logic [W-1:0]  state_q, state_d;
    logic          spike_q, spike_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] sum;
    logic [W-1:0]  sat;

    always_comb begin
        weight_d = weight_q;
        thr_d    = thr_q;
        if (cfg_we) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (cfg_addr == AW'(i)) weight_d[i] = cfg_data;
            end
            if (cfg_addr == AW'(N_IN)) thr_d = cfg_data;
        end
    end

    // Integration uses the registered weights/threshold, so a same-edge write lands after the step.
    always_comb begin
        sum = SW'(state_q) - SW'(state_q >> LEAK_SHIFT);
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (in_spk[i]) sum = sum + SW'(weight_q[i]);
        end
        if (|sum[SW-1:W]) sat = '1;
        else              sat = sum[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        spike_d = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            if (cnt_q != '0) begin
                state_d = '0;
                cnt_d   = cnt_q - CW'(1);
            end else if (sat >= thr_q) begin
                spike_d = 1'b1;
                state_d = '0;
                cnt_d   = CW'(REFRAC);
            end else begin
                state_d = sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_IN; i++) weight_q[i] <= '0;
            thr_q   <= {1'b1, {(W-1){1'b0}}};
            state_q <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            weight_q <= weight_d;
            thr_q    <= thr_d;
            state_q  <= state_d;
            spike_q  <= spike_d;
            cnt_q    <= cnt_d;
        end
    end

    assign spike  = spike_q;
    assign state  = state_q;
    assign refrac = (cnt_q != '0);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron at default parameters.
module tb_lif_neuron;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] in_spk;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       spike;
    logic [7:0] state;
    logic       refrac;

    int n_checks = 0;
    int n_fail   = 0;

    lif_neuron #(.N_IN(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_spk(in_spk),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .spike(spike), .state(state), .refrac(refrac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] st, input logic sp, input logic rf);
        chk({tag, ".state"},  16'(state),  16'(st));
        chk({tag, ".spike"},  16'(spike),  16'(sp));
        chk({tag, ".refrac"}, 16'(refrac), 16'(rf));
    endtask

    task automatic cfg(input logic [2:0] a, input logic [7:0] d);
        en = 1'b0; cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic step(input logic e, input logic [3:0] s);
        en = e; in_spk = s;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        expect_out(tag, 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_we = 1'b0; en = 1'b0; in_spk = '0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_spk = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        #2;
        expect_out("por", 8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Leak convergence with an enable gap at state 88
        cfg(3'd0, 8'd50);
        step(1'b1, 4'b0001); expect_out("leak1", 8'd50, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak2", 8'd75, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak3", 8'd88, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0001); expect_out("gate", 8'd88, 1'b0, 1'b0);
        end
        step(1'b1, 4'b0001); expect_out("leak4", 8'd94, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak5", 8'd97, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak6", 8'd99, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak7", 8'd100, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("leak8", 8'd100, 1'b0, 1'b0);

        // Default threshold 128: just below, then crossing
        do_reset("rst_b");
        cfg(3'd0, 8'd127);
        step(1'b1, 4'b0001); expect_out("thr127", 8'd127, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("thr191", 8'd0, 1'b1, 1'b1);
        do_reset("rst_b2");
        cfg(3'd0, 8'd128);
        step(1'b1, 4'b0001); expect_out("thr_eq", 8'd0, 1'b1, 1'b1);

        // Threshold 90; out-of-range addresses must not touch anything
        do_reset("rst_c");
        cfg(3'd0, 8'd50);
        cfg(3'd4, 8'd90);
        cfg(3'd5, 8'd10);
        cfg(3'd7, 8'd10);
        step(1'b1, 4'b0001); expect_out("cross1", 8'd50, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("cross2", 8'd75, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("cross3", 8'd88, 1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("fire",   8'd0,  1'b1, 1'b1);
        step(1'b1, 4'b0001); expect_out("ref1",   8'd0,  1'b0, 1'b1);
        step(1'b1, 4'b0001); expect_out("ref2",   8'd0,  1'b0, 1'b0);
        step(1'b1, 4'b0001); expect_out("post",   8'd50, 1'b0, 1'b0);

        // Saturation and firing rate, plus enable gating during refractory
        do_reset("rst_d");
        for (int a = 0; a < 4; a++) cfg(3'(a), 8'd255);
        step(1'b1, 4'b1111); expect_out("sat1", 8'd0, 1'b1, 1'b1);
        step(1'b1, 4'b1111); expect_out("sat2", 8'd0, 1'b0, 1'b1);
        step(1'b1, 4'b1111); expect_out("sat3", 8'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111); expect_out("sat4", 8'd0, 1'b1, 1'b1);
        step(1'b1, 4'b1111); expect_out("sat5", 8'd0, 1'b0, 1'b1);
        step(1'b0, 4'b1111); expect_out("sat_hold", 8'd0, 1'b0, 1'b1);
        step(1'b1, 4'b1111); expect_out("sat6", 8'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111); expect_out("sat7", 8'd0, 1'b1, 1'b1);
        step(1'b0, 4'b1111); expect_out("en_off", 8'd0, 1'b0, 1'b1);

        // Write coinciding with a step uses the old weight
        do_reset("rst_e");
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd10;
        step(1'b1, 4'b0010); cfg_we = 1'b0;
        expect_out("wr_same", 8'd0, 1'b0, 1'b0);
        step(1'b1, 4'b0010); expect_out("wr_next", 8'd10, 1'b0, 1'b0);
        step(1'b1, 4'b0010); expect_out("wr_leak", 8'd15, 1'b0, 1'b0);

        // Threshold 0 fires on an idle step
        do_reset("rst_f");
        cfg(3'd4, 8'd0);
        step(1'b1, 4'b0000); expect_out("thr0", 8'd0, 1'b1, 1'b1);

        // Reset mid-refractory with a pending write: write and threshold 0 discarded
        en = 1'b1; in_spk = 4'b0001; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd200;
        do_reset("rst_g");
        step(1'b1, 4'b0001); expect_out("after_rst", 8'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0000);
        chk("final_spike", 16'(spike), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
